// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: framed command parser behind a UART receive stage.
// Frame format: SYNC, LEN (1..8), LEN payload bytes, CSUM (LEN ^ payload bytes).
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-high reset
//   rx_data     - received byte
//   rx_valid    - one-cycle strobe qualifying rx_data
//   cmd_len     - payload length of the last good frame
//   cmd_data    - payload of the last good frame, byte i at [8i+7:8i]
//   frame_valid - one-cycle pulse when a good frame completes
//   frame_err   - one-cycle pulse when a frame is aborted (bad LEN, bad CSUM, timeout)
//   busy        - high whenever the parser is not idle
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT = 52080,
  parameter logic [7:0]  SYNC    = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [3:0]  cmd_len,
  output logic [63:0] cmd_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TMO_W   = 17;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAY, S_CSUM} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [LEN_W-1:0]   idx_q, idx_nxt;
  logic [7:0]         csum_q, csum_nxt;
  logic [DATA_W-1:0]  shadow_q, shadow_nxt;
  logic [TMO_W-1:0]   tmo_q, tmo_nxt;
  logic [LEN_W-1:0]   cmd_len_nxt;
  logic [DATA_W-1:0]  cmd_data_nxt;
  logic               fv_nxt, fe_nxt, busy_nxt;
  logic               tmo_expired;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      cmd_len     <= '0;
      cmd_data    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      idx_q       <= idx_nxt;
      csum_q      <= csum_nxt;
      shadow_q    <= shadow_nxt;
      tmo_q       <= tmo_nxt;
      cmd_len     <= cmd_len_nxt;
      cmd_data    <= cmd_data_nxt;
      frame_valid <= fv_nxt;
      frame_err   <= fe_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    idx_nxt      = idx_q;
    csum_nxt     = csum_q;
    shadow_nxt   = shadow_q;
    cmd_len_nxt  = cmd_len;
    cmd_data_nxt = cmd_data;
    fv_nxt       = 1'b0;
    fe_nxt       = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout
    tmo_expired = (state != S_IDLE) && !rx_valid && (tmo_q == TMO_W'(TIMEOUT - 1));

    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC)) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if ((rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN))) begin
            len_nxt    = rx_data[LEN_W-1:0];
            csum_nxt   = rx_data;
            idx_nxt    = '0;
            shadow_nxt = '0;
            state_nxt  = S_PAY;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_PAY: begin
        if (rx_valid) begin
          shadow_nxt[{idx_q[2:0], 3'b000} +: 8] = rx_data;
          csum_nxt = csum_q ^ rx_data;
          idx_nxt  = idx_q + LEN_W'(1);
          if (idx_nxt == len_q) state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            cmd_data_nxt = shadow_q;
            cmd_len_nxt  = len_q;
            fv_nxt       = 1'b1;
          end else begin
            fe_nxt = 1'b1;
          end
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (tmo_expired) begin
      state_nxt = S_IDLE;
      fe_nxt    = 1'b1;
    end

    // Inter-byte timer restarts on every byte and whenever the parser goes idle
    if (rx_valid || (state_nxt == S_IDLE)) tmo_nxt = '0;
    else                                   tmo_nxt = tmo_q + TMO_W'(1);

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
